bat_memory: RTL and testbench

//  Word-addressed RAM responder on the memory bus driven by the memory test initiator / CPU
//  (address, load, out_en, data). Writes on load, registered single-cycle-latency read onto a

---
 rtl/bat_memory_pkg.sv | 16 +
 rtl/bat_memory_if.sv | 35 +++
 rtl/bat_memory_mem_array.sv | 36 +++
 rtl/bat_memory.sv | 128 ++++++++++++
 tb/tb_bat_memory.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bat_memory_pkg.sv
// Shared definitions for the bat_memory RAM responder: default bus geometry,
// the word returned for unimplemented addresses, and the controller state type.
package bat_memory_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH_DEF  = 256;
    localparam logic [15:0] FAULT_WORD_DEF = 16'hDEAD;

    // CLEAR: zeroing the array after reset; IDLE: serving bus accesses.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/bat_memory_if.sv
// Memory bus between the master (test initiator / CPU) and the bat_memory responder.
//
// Bus protocol: there is no per-transfer handshake. While ready=1 the responder
// accepts one access per clock: load=1 writes data_in to address at that posedge;
// out_en=1 with load=0 reads address, and the word is driven onto data_out from the
// next posedge until the one after. load wins when both are high. While ready=0
// (clear sequence after reset) every access is ignored. fault is sticky until reset.
// state and drive_en are observation-only copies of the controller state and of
// the data_out drive enable.
interface bat_memory_if #(
    parameter int ADDR_W = bat_memory_pkg::ADDR_W_DEF,
    parameter int DATA_W = bat_memory_pkg::DATA_W_DEF
);
    import bat_memory_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              load;
    logic              out_en;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              fault;
    logic              drive_en;
    state_t            state;

    modport master (
        output address, load, out_en, data_in,
        input  ready, fault, drive_en, state
    );

    modport slave (
        input  address, load, out_en, data_in,
        output ready, fault, drive_en, state
    );

endinterface

// File: rtl/bat_memory_mem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read
// port. The read register is reset; the array itself is zeroed by the controller.
module bat_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, one cycle latency, holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/bat_memory.sv
// Word-addressed RAM responder. After reset it walks every word writing zero
// (ready=0), then serves single-cycle writes and one-cycle-latency reads onto a
// tristate data bus. Accesses at or above DEPTH are dropped (writes) or answered
// with FAULT_WORD (reads) and set a sticky fault flag.
module bat_memory
    import bat_memory_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DEPTH      = DEPTH_DEF,
    parameter logic [DATA_W-1:0] FAULT_WORD = FAULT_WORD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    bat_memory_if.slave        bus,
    output wire  [DATA_W-1:0]  data_out
);

    // DEPTH is a power of two of at least 2, so IDX_W low address bits index the array.
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [IDX_W-1:0]  clr_ptr;
    logic              ready_q;
    logic              fault_q;
    logic              oe_q;
    logic              oob_q;

    logic              in_range;
    logic              idle_acc;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [DATA_W-1:0] arr_rd;

    // Full-width compare: high address bits never alias onto the array.
    assign in_range = ({1'b0, bus.address} < DEPTH_X);

    // Accesses count only in IDLE and never in a reset cycle.
    assign idle_acc = (state == ST_IDLE) && !reset;

    // Array port steering: the clear walk owns the write port while in CLEAR.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.address[IDX_W-1:0];
        mem_wdata = bus.data_in;
        mem_re    = 1'b0;
        if (state == ST_CLEAR) begin
            mem_we    = !reset;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (idle_acc) begin
            mem_we = bus.load && in_range;
            mem_re = !bus.load && bus.out_en && in_range;
        end
    end

    // Controller: clear walk, access decode, sticky fault and bus drive enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            oe_q    <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    oe_q    <= 1'b0;
                    clr_ptr <= clr_ptr + IDX_W'(1);
                    if (clr_ptr == LAST_IDX) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.load) begin
                        oe_q <= 1'b0;
                        if (!in_range) begin
                            fault_q <= 1'b1;
                        end
                    end else if (bus.out_en) begin
                        oe_q  <= 1'b1;
                        oob_q <= !in_range;
                        if (!in_range) begin
                            fault_q <= 1'b1;
                        end
                    end else begin
                        oe_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    oe_q  <= 1'b0;
                end
            endcase
        end
    end

    bat_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re      (mem_re),
        .raddr   (bus.address[IDX_W-1:0]),
        .rd_data (arr_rd)
    );

    assign bus.ready    = ready_q;
    assign bus.fault    = fault_q;
    assign bus.drive_en = oe_q;
    assign bus.state    = state;

    // Out-of-range reads return FAULT_WORD; the bus floats when no read is pending.
    assign data_out = oe_q ? (oob_q ? FAULT_WORD : arr_rd) : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bat_memory.sv
// Bench for bat_memory: directed bus cycles, a behavioural memory model checked
// every cycle, and literal expectations for the key reads and flags.
module tb_bat_memory;
    import bat_memory_pkg::*;

    localparam int          DW    = 16;
    localparam int          AW    = 16;
    localparam int          DEPTH = 256;
    localparam logic [15:0] FW    = 16'hDEAD;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    wire  [DW-1:0]  data_out;

    bat_memory_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bat_memory #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .DEPTH      (DEPTH),
        .FAULT_WORD (FW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .data_out (data_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory reads as zero after any reset; accesses count only once DEPTH
    // clock edges have passed since reset was released.
    logic [DW-1:0] m_mem [DEPTH];
    int            rel_cnt = 0;
    bit            m_fault = 1'b0;
    bit            m_oe    = 1'b0;
    logic [DW-1:0] m_data  = '0;

    always @(posedge clk) begin
        if (reset) begin
            rel_cnt = 0;
            m_fault = 1'b0;
            m_oe    = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (rel_cnt < DEPTH) begin
            rel_cnt++;
            m_oe = 1'b0;
        end else if (bus.load) begin
            m_oe = 1'b0;
            if (int'(bus.address) < DEPTH) m_mem[int'(bus.address)] = bus.data_in;
            else m_fault = 1'b1;
        end else if (bus.out_en) begin
            m_oe = 1'b1;
            if (int'(bus.address) < DEPTH) m_data = m_mem[int'(bus.address)];
            else begin
                m_data  = FW;
                m_fault = 1'b1;
            end
        end else begin
            m_oe = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("ready",    32'(bus.ready),    32'(rel_cnt >= DEPTH));
        chk("fault",    32'(bus.fault),    32'(m_fault));
        chk("drive_en", 32'(bus.drive_en), 32'(m_oe));
        chk("state",    32'(bus.state),    32'((rel_cnt >= DEPTH) ? ST_IDLE : ST_CLEAR));
        if (m_oe) chk("data_out", 32'(data_out), 32'(m_data));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit ld, input bit oe, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.load    = ld;
        bus.out_en  = oe;
        bus.address = a;
        bus.data_in = d;
    endtask

    // Idles (or issues random accesses) until ready rises; n = edges waited.
    task automatic wait_ready(input bit noisy, output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < DEPTH + 20) begin
            if (noisy)
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, DEPTH - 1)), 16'($urandom_range(1, 16'hFFFF)));
            else
                cyc(1'b0, 1'b0, 16'h0, 16'h0);
            n++;
        end
        bus.load   = 1'b0;
        bus.out_en = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    logic [15:0] tbl_a [4];
    logic [15:0] tbl_d [4];

    initial begin
        int n;
        bus.load    = 1'b0;
        bus.out_en  = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        tbl_a[0] = 16'h0001; tbl_d[0] = 16'h0F0F;
        tbl_a[1] = 16'h007F; tbl_d[1] = 16'h8001;
        tbl_a[2] = 16'h00FF; tbl_d[2] = 16'hFFFF;
        tbl_a[3] = 16'h0080; tbl_d[3] = 16'h3C3C;

        // 1: two reset edges, then count edges until ready.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("lit_ready_after_rst", 32'(bus.ready), 32'h0);
        wait_ready(1'b0, n);
        chk("lit_clear_len", 32'(n), 32'(DEPTH));

        // 2: writes then back-to-back reads.
        cyc(1'b1, 1'b0, 16'h0000, 16'h5A5A);
        cyc(1'b1, 1'b0, 16'h0010, 16'hA5A5);
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0010, 16'h0000);
        chk("lit_rd_0000", 32'(data_out), 32'h5A5A);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("lit_rd_0010", 32'(data_out), 32'hA5A5);

        // 3: load and out_en together: write wins, bus stays undriven.
        cyc(1'b1, 1'b1, 16'h0010, 16'h1234);
        cyc(1'b0, 1'b1, 16'h0010, 16'h0000);
        chk("lit_ld_oe_undriven", 32'(bus.drive_en), 32'h0);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("lit_rd_1234", 32'(data_out), 32'h1234);

        // 4: out-of-range read and write.
        chk("lit_fault_clean", 32'(bus.fault), 32'h0);
        cyc(1'b0, 1'b1, 16'h0100, 16'h0000);
        cyc(1'b1, 1'b0, 16'hFFFF, 16'h7777);
        chk("lit_rd_oob", 32'(data_out), 32'hDEAD);
        chk("lit_fault_set", 32'(bus.fault), 32'h1);
        cyc(1'b0, 1'b1, 16'h00FF, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("lit_no_alias", 32'(data_out), 32'h0000);
        chk("lit_fault_sticky", 32'(bus.fault), 32'h1);

        // 6a: table of writes, load-only and idle cycles, then read back.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, tbl_a[i], tbl_d[i]);
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
            chk("lit_idle_undriven", 32'(bus.drive_en), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, tbl_a[i], 16'h0000);
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
            chk("lit_tbl_rd", 32'(data_out), 32'(tbl_d[i]));
        end

        // 5: reset during a read; memory comes back zeroed.
        cyc(1'b1, 1'b0, 16'h0005, 16'hBEEF);
        cyc(1'b0, 1'b1, 16'h0005, 16'h0000);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("lit_rst_abort_read", 32'(bus.drive_en), 32'h0);
        chk("lit_rst_fault_clr", 32'(bus.fault), 32'h0);
        reset = 1'b0;

        // 6b: random traffic while clearing must not land in memory.
        wait_ready(1'b1, n);
        chk("lit_clear_len2", 32'(n), 32'(DEPTH));
        cyc(1'b0, 1'b1, 16'h0005, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000);
        chk("lit_rd_after_rst", 32'(data_out), 32'h0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, tbl_a[i], 16'h0000);
            chk("lit_zero_after_clear", 32'(data_out), 32'h0000);
        end
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("lit_zero_last", 32'(data_out), 32'h0000);

        repeat (3) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
